// File: rtl/udp_tx_packetizer.sv
`timescale 1ns/1ps
// UDP tx packetizer: frames PAYLOAD_WORDS 32-bit samples behind a 4-byte
// sequence header into the tx data FIFO, then writes one 96-bit descriptor
// (port, MAC, IP) into the tx status FIFO.
module udp_tx_packetizer #(
  parameter int unsigned PAYLOAD_WORDS   = 256,
  parameter int unsigned DATA_FIFO_WORDS = 8192
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] dest_port,
  input  logic [47:0] dest_mac,
  input  logic [31:0] dest_ip,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        wrreq_data,
  output logic [7:0]  data_to_fifo,
  input  logic        wrfull_data,
  input  logic [12:0] wrusedw_data,
  output logic        wrreq_status,
  output logic [95:0] status_to_fifo,
  input  logic        wrfull_status,
  input  logic [7:0]  wrusedw_status,
  output logic [31:0] seq_num,
  output logic        busy
);

  localparam int unsigned PKT_BYTES    = 4 + 4 * PAYLOAD_WORDS;
  localparam int unsigned SPACE_LIMIT  = DATA_FIFO_WORDS - 1 - PKT_BYTES;
  localparam int unsigned CNT_W        = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [7:0]  STATUS_LIMIT = 8'd254;

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, HEADER, PAYLOAD, STATUS} state_t;

  state_t             state_q, state_d;
  logic [31:0]        hold_q, hold_d;
  logic               full_q, full_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        port_q, port_d;
  logic [47:0]        mac_q, mac_d;
  logic [31:0]        ip_q, ip_d;
  logic [31:0]        seq_d;
  logic               wr_data_d, wr_status_d, s_ready_d, busy_d;
  logic [7:0]         byte_d;
  logic [95:0]        status_d;
  logic               space_ok, capture, owed;

  // Select byte i of a word, MSB first
  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign space_ok = (32'(wrusedw_data) <= SPACE_LIMIT) && !wrfull_data &&
                    !wrfull_status && (wrusedw_status < STATUS_LIMIT);
  assign capture  = s_valid && s_ready;
  assign owed     = cnt_q < CNT_W'(PAYLOAD_WORDS);

  // Next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    full_d      = full_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    mac_d       = mac_q;
    ip_d        = ip_q;
    seq_d       = seq_num;
    wr_data_d   = 1'b0;
    byte_d      = data_to_fifo;
    wr_status_d = 1'b0;
    status_d    = status_to_fifo;

    case (state_q)
      IDLE: begin
        if (enable && s_valid) state_d = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          port_d  = dest_port;
          mac_d   = dest_mac;
          ip_d    = dest_ip;
          idx_d   = 2'd0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        wr_data_d = 1'b1;
        byte_d    = pick(seq_num, idx_q);
        idx_d     = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          full_d  = 1'b0;
          cnt_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!full_q) begin
          // Empty register: forward the MSB straight away to avoid a bubble
          if (capture) begin
            wr_data_d = 1'b1;
            byte_d    = s_data[31:24];
            hold_d    = s_data;
            full_d    = 1'b1;
            idx_d     = 2'd1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end else begin
          wr_data_d = 1'b1;
          byte_d    = pick(hold_q, idx_q);
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (capture) begin
              hold_d = s_data;
              cnt_d  = cnt_q + CNT_W'(1);
            end else begin
              full_d = 1'b0;
              if (!owed) state_d = STATUS;
            end
          end
        end
      end
      STATUS: begin
        wr_status_d = 1'b1;
        status_d    = {port_q, mac_q, ip_q};
        seq_d       = seq_num + 32'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == PAYLOAD) &&
                (!full_d || (idx_d == 2'd3 && cnt_d < CNT_W'(PAYLOAD_WORDS)));
    busy_d    = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      full_q         <= 1'b0;
      idx_q          <= '0;
      cnt_q          <= '0;
      port_q         <= '0;
      mac_q          <= '0;
      ip_q           <= '0;
      seq_num        <= '0;
      s_ready        <= 1'b0;
      wrreq_data     <= 1'b0;
      data_to_fifo   <= '0;
      wrreq_status   <= 1'b0;
      status_to_fifo <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      full_q         <= full_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      port_q         <= port_d;
      mac_q          <= mac_d;
      ip_q           <= ip_d;
      seq_num        <= seq_d;
      s_ready        <= s_ready_d;
      wrreq_data     <= wr_data_d;
      data_to_fifo   <= byte_d;
      wrreq_status   <= wr_status_d;
      status_to_fifo <= status_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
`timescale 1ns/1ps
// Directed bench for udp_tx_packetizer with PAYLOAD_WORDS=2 (12-byte packets)
module tb_udp_tx_packetizer;

  localparam int unsigned PW  = 2;
  localparam int unsigned DFW = 8192;
  localparam int unsigned NB  = 4 + 4 * PW;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] dest_port;
  logic [47:0] dest_mac;
  logic [31:0] dest_ip;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wrreq_data;
  logic [7:0]  data_to_fifo;
  logic        wrfull_data;
  logic [12:0] wrusedw_data;
  logic        wrreq_status;
  logic [95:0] status_to_fifo;
  logic        wrfull_status;
  logic [7:0]  wrusedw_status;
  logic [31:0] seq_num;
  logic        busy;

  udp_tx_packetizer #(.PAYLOAD_WORDS(PW), .DATA_FIFO_WORDS(DFW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .dest_port(dest_port), .dest_mac(dest_mac), .dest_ip(dest_ip),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wrreq_data(wrreq_data), .data_to_fifo(data_to_fifo),
    .wrfull_data(wrfull_data), .wrusedw_data(wrusedw_data),
    .wrreq_status(wrreq_status), .status_to_fifo(status_to_fifo),
    .wrfull_status(wrfull_status), .wrusedw_status(wrusedw_status),
    .seq_num(seq_num), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO-side monitor, sampled on the falling edge
  logic [7:0]  data_q[$];
  int          data_cyc[$];
  logic [95:0] st_q[$];
  int          st_at[$];
  int          cyc     = 0;
  bit          overlap = 1'b0;
  bit          rdy_idle = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (wrreq_data) begin
      data_q.push_back(data_to_fifo);
      data_cyc.push_back(cyc);
    end
    if (wrreq_status) begin
      st_q.push_back(status_to_fifo);
      st_at.push_back(data_q.size());
    end
    if (wrreq_data && wrreq_status) overlap = 1'b1;
    if (s_ready && !busy) rdy_idle = 1'b1;
  end

  function automatic logic [95:0] collect(input int base);
    logic [95:0] r;
    for (int i = 0; i < 12; i++)
      r[95-8*i -: 8] = (base + i < data_q.size()) ? data_q[base+i] : 8'hxx;
    return r;
  endfunction

  bit phase = 1'b0;

  // Offer two words; toggle=1 drops s_valid every other cycle
  task automatic send_words(input logic [31:0] w0, input logic [31:0] w1,
                            input bit toggle, output bit ok);
    logic [31:0] w [2];
    bit acc;
    int t;
    w[0] = w0;
    w[1] = w1;
    ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
        @(negedge clock);
        phase   = ~phase;
        s_valid = toggle ? phase : 1'b1;
        s_data  = w[k];
        acc     = s_valid && s_ready;
        t++;
      end
      if (!acc) ok = 1'b0;
    end
    @(negedge clock);
    s_valid = 1'b0;
  endtask

  task automatic wait_status(input int sbase, output bit ok);
    int t = 0;
    while (st_q.size() <= sbase && t < 50) begin
      @(negedge clock);
      t++;
    end
    ok = (st_q.size() > sbase);
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    bit          toggle;
    logic [15:0] port;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [95:0] exp_bytes;
    logic [95:0] exp_status;
    logic [31:0] exp_seq;
  } vec_t;

  vec_t vecs [4];

  // Send one packet and check its bytes, descriptor and sequence number
  task automatic run_pkt(input string tag, input vec_t v);
    int base, sbase;
    bit ok;
    base  = data_q.size();
    sbase = st_q.size();
    dest_port = v.port;
    dest_mac  = v.mac;
    dest_ip   = v.ip;
    send_words(v.w0, v.w1, v.toggle, ok);
    chk({tag, "_accept"}, 96'(ok), 96'(1));
    wait_status(sbase, ok);
    chk({tag, "_status_seen"}, 96'(ok), 96'(1));
    chk({tag, "_bytes"}, collect(base), v.exp_bytes);
    chk({tag, "_nbytes"}, 96'(data_q.size() - base), 96'(NB));
    if (ok) begin
      chk({tag, "_status"}, st_q[sbase], v.exp_status);
      chk({tag, "_order"}, 96'(st_at[sbase] - base), 96'(NB));
    end
    chk({tag, "_seq"}, 96'(seq_num), 96'(v.exp_seq));
    if (!v.toggle && data_q.size() >= base + 12)
      chk({tag, "_contig"}, 96'(data_cyc[base+11] - data_cyc[base]), 96'(11));
  endtask

  initial begin
    int base, sbase, t;
    vec_t v;

    vecs[0] = '{32'h11223344, 32'h55667788, 1'b0, 16'h1234, 48'h001122334455, 32'hC0A80101,
                96'h00000000_11223344_55667788, {16'h1234, 48'h001122334455, 32'hC0A80101}, 32'd1};
    vecs[1] = '{32'hDEADBEEF, 32'h01020304, 1'b1, 16'h0050, 48'hAABBCCDDEEFF, 32'h0A000001,
                96'h00000001_DEADBEEF_01020304, {16'h0050, 48'hAABBCCDDEEFF, 32'h0A000001}, 32'd2};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 16'hFFFF, 48'hFFFFFFFFFFFF, 32'hFFFFFFFF,
                96'h00000002_FFFFFFFF_00000000, {96{1'b1}}, 32'd3};
    vecs[3] = '{32'h80000001, 32'h7F7F7F7E, 1'b1, 16'h0000, 48'h0, 32'h0,
                96'h00000003_80000001_7F7F7F7E, 96'h0, 32'd4};

    reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    dest_port = '0; dest_mac = '0; dest_ip = '0;
    wrfull_data = 1'b0; wrusedw_data = '0; wrfull_status = 1'b0; wrusedw_status = '0;

    repeat (3) @(negedge clock);
    chk("rst_wrreq_data", 96'(wrreq_data), 96'(0));
    chk("rst_wrreq_status", 96'(wrreq_status), 96'(0));
    chk("rst_s_ready", 96'(s_ready), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_data", 96'(data_to_fifo), 96'(0));
    chk("rst_status", status_to_fifo, 96'(0));
    chk("rst_seq", 96'(seq_num), 96'(0));
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 4; i++) run_pkt($sformatf("vec%0d", i), vecs[i]);

    // One byte short of space: hold in WAIT_SPACE, then release; dest_ip changes mid-payload
    base  = data_q.size();
    sbase = st_q.size();
    dest_port = 16'h0007; dest_mac = 48'h0A0B0C0D0E0F; dest_ip = 32'hC0A80101;
    wrusedw_data = 13'(DFW - NB);
    s_valid = 1'b1; s_data = 32'hCAFEF00D;
    repeat (8) @(negedge clock);
    chk("space_no_writes", 96'(data_q.size() - base), 96'(0));
    chk("space_busy", 96'(busy), 96'(1));
    chk("space_s_ready", 96'(s_ready), 96'(0));
    wrusedw_data = 13'(DFW - NB - 1);
    @(negedge clock);
    @(negedge clock);
    chk("space_hdr_start", 96'(wrreq_data), 96'(1));
    begin
      bit ok;
      send_words(32'hCAFEF00D, 32'h12345678, 1'b0, ok);
      chk("space_accept", 96'(ok), 96'(1));
      dest_ip = 32'h0A000001; dest_port = 16'h9999; dest_mac = 48'h1;
      wait_status(sbase, ok);
      chk("space_status_seen", 96'(ok), 96'(1));
      if (ok) chk("ip_latched_status", st_q[sbase], {16'h0007, 48'h0A0B0C0D0E0F, 32'hC0A80101});
    end
    chk("space_bytes", collect(base), 96'h00000004_CAFEF00D_12345678);
    chk("space_seq", 96'(seq_num), 96'(5));
    wrusedw_data = '0;

    // Sequence-number wrap
    @(negedge clock);
    force dut.seq_num = 32'hFFFFFFFF;
    repeat (2) @(negedge clock);
    release dut.seq_num;
    @(negedge clock);
    chk("wrap_preset", 96'(seq_num), 96'(32'hFFFFFFFF));
    v = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 16'h0101, 48'h020202020202, 32'h03030303,
          96'hFFFFFFFF_A5A5A5A5_5A5A5A5A, {16'h0101, 48'h020202020202, 32'h03030303}, 32'd0};
    run_pkt("wrap", v);

    // Reset in the middle of the payload
    base  = data_q.size();
    sbase = st_q.size();
    s_valid = 1'b1; s_data = 32'h01020304;
    t = 0;
    while (data_q.size() - base < 6 && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("rstmid_reached", 96'(data_q.size() - base >= 6), 96'(1));
    reset_n = 1'b0;
    #1;
    chk("rstmid_wrreq_data", 96'(wrreq_data), 96'(0));
    chk("rstmid_busy", 96'(busy), 96'(0));
    chk("rstmid_s_ready", 96'(s_ready), 96'(0));
    chk("rstmid_seq", 96'(seq_num), 96'(0));
    s_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("rstmid_no_status", 96'(st_q.size() - sbase), 96'(0));
    v = '{32'h0BADC0DE, 32'h600DF00D, 1'b0, 16'h4321, 48'h665544332211, 32'h7F000001,
          96'h00000000_0BADC0DE_600DF00D, {16'h4321, 48'h665544332211, 32'h7F000001}, 32'd1};
    run_pkt("after_rst", v);

    chk("never_both_wrreq", 96'(overlap), 96'(0));
    chk("s_ready_only_busy", 96'(rdy_idle), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_packetizer.md
UDP_TX_PACKETIZER -- requirements
Module: udp_tx_packetizer

Interface
REQ-001 SHALL have parameter PAYLOAD_WORDS, default 256: 32-bit sample words per UDP packet, legal range 1..2000.
REQ-002 SHALL have parameter DATA_FIFO_WORDS, default 8192: depth of the downstream tx data FIFO, in bytes.
REQ-003 SHALL have these ports:
- clock, in, 1: single clock, equal to wrclk_udp_txfifo_N.
- reset_n, in, 1: asynchronous reset, active-low.
- enable, in, 1: allows new packets to start.
- dest_port, in, 16: UDP destination port.
- dest_mac, in, 48: destination MAC address.
- dest_ip, in, 32: destination IP address.
- s_data, in, 32: sample word.
- s_valid, in, 1: s_data is valid.
- s_ready, out, 1: block accepts s_data.
- wrreq_data, out, 1: write strobe for the tx data FIFO.
- data_to_fifo, out, 8: payload byte.
- wrfull_data, in, 1: tx data FIFO is full.
- wrusedw_data, in, 13: tx data FIFO fill level.
- wrreq_status, out, 1: write strobe for the tx status FIFO.
- status_to_fifo, out, 96: packet descriptor.
- wrfull_status, in, 1: tx status FIFO is full.
- wrusedw_status, in, 8: tx status FIFO fill level.
- seq_num, out, 32: sequence number of the next packet.
- busy, out, 1: high whenever state is not IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, WAIT_SPACE, HEADER, PAYLOAD and STATUS.
REQ-005 Packet size SHALL be PKT_BYTES = 4 + 4*PAYLOAD_WORDS.
- Byte order: the 4-byte seq header first, then the payload words.
- Every word SHALL be sent MSB byte first.
REQ-006 IDLE -> WAIT_SPACE SHALL occur when enable=1 and s_valid=1.
REQ-007 WAIT_SPACE -> HEADER SHALL occur only when all of the following hold in the same cycle:
- wrusedw_data <= DATA_FIFO_WORDS-1-PKT_BYTES;
- wrfull_data=0;
- wrfull_status=0;
- wrusedw_status < 254.
REQ-008 On the WAIT_SPACE -> HEADER transition, dest_port, dest_mac and dest_ip SHALL be latched. Later input changes SHALL NOT affect the packet in progress.
REQ-009 HEADER SHALL assert wrreq_data for exactly 4 consecutive cycles with data_to_fifo = seq_num[31:24], [23:16], [15:8], [7:0], then move to PAYLOAD.
REQ-010 PAYLOAD SHALL use a 32-bit holding register and a 2-bit byte index.
- s_ready=1 when the register is empty, or when byte index=3 and more words are still owed.
- A word is captured on s_valid & s_ready.
- Each held byte SHALL be written with wrreq_data=1, one byte per cycle.
- Sustained throughput SHALL be 1 byte/cycle while s_valid stays high.
REQ-011 If the holding register empties and s_valid=0, wrreq_data SHALL be 0 and the block SHALL wait. No timeout.
REQ-012 After the byte of word PAYLOAD_WORDS is written, the FSM SHALL go to STATUS.
REQ-013 STATUS SHALL assert wrreq_status for exactly 1 cycle.
- status_to_fifo = {port[95:80], mac[79:32], ip[31:0]}, from the latched values.
- seq_num SHALL increment by 1, mod 2^32 (0xFFFFFFFF wraps to 0x00000000).
- Next state SHALL be IDLE.
REQ-014 wrreq_data and wrreq_status SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-015 s_ready SHALL be 0 in every state except PAYLOAD.
REQ-016 enable=0 during HEADER/PAYLOAD/STATUS SHALL NOT abort the packet; enable is sampled only in IDLE.
REQ-017 wrfull_data SHALL be ignored after WAIT_SPACE; the space check guarantees no overflow.
REQ-018 The status descriptor SHALL always be written after the last data byte of its packet, never before.

Reset
REQ-019 When reset_n=0, the block SHALL asynchronously set:
- state to IDLE;
- s_ready, wrreq_data, wrreq_status and busy to 0;
- data_to_fifo and status_to_fifo to 0;
- seq_num to 0;
- holding register, byte index and word counter to 0.
REQ-020 Reset during a packet SHALL discard that packet. No status word is written for it, and the partial data is flushed by the FIFO's own reset.
REQ-021 The block SHALL leave reset cleanly on the first rising clock edge after reset_n goes high.

Verification
REQ-022 PAYLOAD_WORDS=2, enable=1, words 0x11223344 and 0x55667788 presented back-to-back, empty FIFOs:
- data bytes = 00 00 00 00 11 22 33 44 55 66 77 88 on 12 consecutive cycles;
- then one status write;
- seq_num = 1.
REQ-023 wrusedw_data = DATA_FIFO_WORDS-PKT_BYTES (one byte too many):
- block stays in WAIT_SPACE with no writes;
- when wrusedw_data drops by 1, HEADER starts on the next cycle.
REQ-024 s_valid toggling 1/0 every cycle during PAYLOAD:
- all bytes correct and in order;
- wrreq_data gaps only when the holding register is empty;
- exactly 4*PAYLOAD_WORDS payload writes.
REQ-025 seq_num forced to 0xFFFFFFFF:
- header bytes FF FF FF FF;
- after the status write, seq_num = 0x00000000.
REQ-026 dest_ip changed mid-payload from 0xC0A80101 to 0x0A000001: status_to_fifo[31:0] = 0xC0A80101.
REQ-027 reset_n pulsed low during PAYLOAD:
- outputs go to 0 immediately, with no status write;
- the next packet's header is 00 00 00 00.
